// File: rtl/dmem_resp_if.sv
// Request/response bus between the CPU memory stage (master) and the data-memory
// responder (slave): one load or store in flight at a time, completed by an ack pulse.
interface dmem_resp_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, ack, err, busy
  );
endinterface

// File: rtl/dmem_resp.sv
// Data-memory responder: accepts one load/store, completes it after LATENCY cycles with
// ack (plus err for misaligned or out-of-range addresses); stores honour byte enables.
module dmem_resp #(
  parameter int AW      = 10,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  dmem_resp_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state;
  logic [3:0]  cnt;

  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;

  logic [31:0] mem [0:(2**AW)-1];

  logic          c_we;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic [3:0]    c_be;
  logic          c_err;
  logic          commit;
  logic [AW-1:0] c_idx;

  // The committing request is the captured one, except with LATENCY = 1 where it
  // commits on its own acceptance edge and must be taken straight off the bus.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    c_we    = cap_we;
    c_addr  = cap_addr;
    c_wdata = cap_wdata;
    c_be    = cap_be;
    if (state == IDLE) begin
      c_we    = bus.we;
      c_addr  = bus.addr;
      c_wdata = bus.wdata;
      c_be    = bus.be;
    end
    commit = ((state == IDLE) && bus.req && (LATENCY == 1)) ||
             ((state == WAIT) && (cnt == 4'd1));
  end

  assign c_err = (c_addr[1:0] != 2'b00) || (|c_addr[31:AW+2]);
  assign c_idx = c_addr[AW+1:2];

  // NOTE: datapath holding registers and the storage array carry no reset; only
  // control state and outputs are cleared, so reset never touches committed data.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req) begin
      cap_we    <= bus.we;
      cap_addr  <= bus.addr;
      cap_wdata <= bus.wdata;
      cap_be    <= bus.be;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && commit && c_we && !c_err) begin
      for (int i = 0; i < 4; i++) begin
        if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      bus.ack   <= 1'b0;
      bus.err   <= 1'b0;
      bus.busy  <= 1'b0;
      bus.rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          bus.ack <= 1'b0;
          bus.err <= 1'b0;
          if (bus.req) begin
            cnt      <= CNT_INIT;
            bus.busy <= 1'b1;
            if (LATENCY == 1) begin
              state   <= RESP;
              bus.ack <= 1'b1;
              bus.err <= c_err;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state   <= RESP;
            bus.ack <= 1'b1;
            bus.err <= c_err;
          end
        end
        RESP: begin
          state    <= IDLE;
          bus.ack  <= 1'b0;
          bus.err  <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (commit && !c_we && !c_err) bus.rdata <= mem[c_idx];
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: three instances (LATENCY 2, 1, 4) share one stimulus stream and
// are compared every cycle against a timestamp-based transaction model.
module tb_dmem_resp;

  localparam int AW = 10;
  localparam int NI = 3;

  function automatic int lat_f(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  be = 4'd0;

  logic        o_ack   [NI];
  logic        o_err   [NI];
  logic        o_busy  [NI];
  logic [31:0] o_rdata [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_resp_if bus ();
    assign bus.req   = req;
    assign bus.we    = we;
    assign bus.addr  = addr;
    assign bus.wdata = wdata;
    assign bus.be    = be;
    assign o_ack[g]   = bus.ack;
    assign o_err[g]   = bus.err;
    assign o_busy[g]  = bus.busy;
    assign o_rdata[g] = bus.rdata;
    dmem_resp #(.AW(AW), .LATENCY(lat_f(g))) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Transaction model: edge-numbered timestamps; byte-addressed memory per instance.
  int          cyc = 0;
  bit          pend      [NI];
  int          acc_edge  [NI];
  int          free_edge [NI];
  logic        m_we      [NI];
  logic [31:0] m_addr    [NI];
  logic [31:0] m_wdata   [NI];
  logic [3:0]  m_be      [NI];
  logic        e_ack     [NI];
  logic        e_err     [NI];
  logic        e_busy    [NI];
  logic [31:0] e_rdata   [NI];
  bit          rd_known  [NI];
  logic [7:0]  mem_m [int];

  int ack_cnt  [NI] = '{0, 0, 0};
  logic last_err [NI];

  function automatic int key(input int k, input logic [31:0] a);
    return k * 65536 + int'(a[15:0]);
  endfunction

  task automatic model_commit(input int k);
    bit bad;
    bit known;
    logic [31:0] word;
    bad = (m_addr[k][1:0] != 2'b00) || ((m_addr[k] >> (AW + 2)) != 0);
    e_ack[k] = 1'b1;
    e_err[k] = bad;
    if (!bad) begin
      if (m_we[k]) begin
        for (int i = 0; i < 4; i++)
          if (m_be[k][i]) mem_m[key(k, m_addr[k] + i)] = m_wdata[k][8*i +: 8];
      end else begin
        known = 1'b1;
        word = 32'd0;
        for (int i = 0; i < 4; i++) begin
          if (mem_m.exists(key(k, m_addr[k] + i))) word[8*i +: 8] = mem_m[key(k, m_addr[k] + i)];
          else known = 1'b0;
        end
        e_rdata[k] = word;
        rd_known[k] = known;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int k = 0; k < NI; k++) begin
      e_ack[k] = 1'b0;
      e_err[k] = 1'b0;
      if (!rst) begin
        pend[k]      = 1'b0;
        free_edge[k] = cyc + 1;
        e_busy[k]    = 1'b0;
        e_rdata[k]   = 32'd0;
        rd_known[k]  = 1'b1;
      end else begin
        if (!pend[k] && cyc >= free_edge[k] && req) begin
          pend[k]     = 1'b1;
          acc_edge[k] = cyc;
          m_we[k]     = we;
          m_addr[k]   = addr;
          m_wdata[k]  = wdata;
          m_be[k]     = be;
        end
        if (pend[k] && cyc == acc_edge[k] + lat_f(k) - 1) begin
          model_commit(k);
          pend[k]      = 1'b0;
          free_edge[k] = cyc + 2;
        end
        e_busy[k] = pend[k] || e_ack[k];
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int k = 0; k < NI; k++) begin
        check($sformatf("ack[%0d]", k), 32'(o_ack[k]), 32'(e_ack[k]));
        check($sformatf("err[%0d]", k), 32'(o_err[k]), 32'(e_err[k]));
        check($sformatf("busy[%0d]", k), 32'(o_busy[k]), 32'(e_busy[k]));
        if (rd_known[k]) check($sformatf("rdata[%0d]", k), o_rdata[k], e_rdata[k]);
        if (o_ack[k] === 1'b1) begin
          ack_cnt[k]++;
          last_err[k] = o_err[k];
        end
      end
    end
  end

  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(negedge clk);
    req = 1'b0;
    repeat (7) @(negedge clk);
    #1;
  endtask

  int a0, a1, a2;

  initial begin
    // Reset held two edges with a request pending: nothing may be accepted.
    rst = 1'b0; req = 1'b1; we = 1'b0; addr = 32'h10;
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset busy[%0d]", k), 32'(o_busy[k]), 32'd0);
      check($sformatf("reset rdata[%0d]", k), o_rdata[k], 32'd0);
    end
    req = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset no ack", 32'(ack_cnt[0] + ack_cnt[1] + ack_cnt[2]), 32'd0);

    txn(1'b1, 32'h0,  32'h0123_4567, 4'hF);
    txn(1'b1, 32'h20, 32'h0BAD_F00D, 4'hF);

    // Full-word store then load.
    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    check("store err", 32'(last_err[0]), 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'h0);
    check("load DEADBEEF", o_rdata[0], 32'hDEAD_BEEF);

    // Partial store: bytes 0 and 2 replaced.
    txn(1'b1, 32'h10, 32'h1122_3344, 4'b0101);
    txn(1'b0, 32'h10, 32'h0, 4'h0);
    for (int k = 0; k < NI; k++)
      check($sformatf("byte merge[%0d]", k), o_rdata[k], 32'hDE22_BE44);

    // Misaligned load, then out-of-range store aliasing word 0.
    txn(1'b0, 32'h13, 32'h0, 4'h0);
    check("misaligned err", 32'(last_err[0]), 32'd1);
    check("misaligned rdata held", o_rdata[0], 32'hDE22_BE44);
    txn(1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF);
    check("range err", 32'(last_err[2]), 32'd1);
    txn(1'b0, 32'h0, 32'h0, 4'h0);
    check("range no write", o_rdata[1], 32'h0123_4567);
    check("range load ok", 32'(last_err[1]), 32'd0);

    // req held for six edges.
    a0 = ack_cnt[0]; a1 = ack_cnt[1]; a2 = ack_cnt[2];
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h10;
    repeat (6) @(negedge clk);
    req = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("held acks L1", 32'(ack_cnt[1] - a1), 32'd3);
    check("held acks L2", 32'(ack_cnt[0] - a0), 32'd2);
    check("held acks L4", 32'(ack_cnt[2] - a2), 32'd2);

    // Requests during busy are dropped.
    a0 = ack_cnt[0]; a1 = ack_cnt[1]; a2 = ack_cnt[2];
    @(negedge clk); req = 1'b1;
    @(negedge clk);
    @(negedge clk); req = 1'b0;
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("busy drop L1", 32'(ack_cnt[1] - a1), 32'd2);
    check("busy drop L2", 32'(ack_cnt[0] - a0), 32'd2);
    check("busy drop L4", 32'(ack_cnt[2] - a2), 32'd1);

    // Reset two edges after accepting a store.
    a0 = ack_cnt[0]; a2 = ack_cnt[2];
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hCAFE_F00D; be = 4'hF;
    @(negedge clk); req = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    check("mid-reset no ack L4", 32'(ack_cnt[2] - a2), 32'd0);
    check("mid-reset ack L2", 32'(ack_cnt[0] - a0), 32'd1);
    check("mid-reset rdata", o_rdata[2], 32'd0);
    repeat (3) @(negedge clk);
    txn(1'b0, 32'h20, 32'h0, 4'h0);
    check("discarded store L4", o_rdata[2], 32'h0BAD_F00D);
    check("committed store L2", o_rdata[0], 32'hCAFE_F00D);
    check("committed store L1", o_rdata[1], 32'hCAFE_F00D);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder: the memory-side end of the CPU's data port. It accepts one load or store request at a time from the memory stage over a req/ack handshake and completes it after a fixed, parameterised latency. Stores support byte enables. Misaligned and out-of-range accesses finish with an error response instead of touching storage. The block stands in for a slow data RAM so the pipeline's stall logic can be exercised against it.

## Interface

**Parameters**

- `AW`, default 10: word-address width. Storage holds 2^AW 32-bit words; the byte address range is 0 .. 4·2^AW − 1.
- `LATENCY`, default 2: cycles from request acceptance to `ack`. Legal range 1..15.

**Ports**

- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `req` in 1: request valid. Sampled only while `busy` = 0.
- `we` in 1: 1 = store, 0 = load. Qualified by `req`.
- `addr` in 32: byte address. Qualified by `req`.
- `wdata` in 32: store data. Qualified by `req` and `we`.
- `be` in 4: byte enables for a store; `be[i]` selects `wdata[8i+7:8i]`. Ignored on loads.
- `rdata` out 32: load data. Valid in the `ack` cycle of a successful load; held until the next successful load completes.
- `ack` out 1: one-cycle completion pulse.
- `err` out 1: asserted with `ack` when the access was rejected.
- `busy` out 1: request in flight; `req` is ignored while high.

## Operation

**States**

- IDLE
  - `busy` = 0.
  - If `req` = 1: capture `we`, `addr`, `wdata`, `be`; load `cnt` = LATENCY − 1.
  - Next state is WAIT if LATENCY > 1, otherwise RESP.
- WAIT
  - `busy` = 1.
  - `cnt` decrements each cycle. When `cnt` = 1, the next state is RESP.
- RESP
  - `busy` = 1, `ack` = 1 for exactly this cycle.
  - Next state is IDLE unconditionally.
  - `req` presented in this cycle is not accepted.

**Error check** (evaluated on the captured request)

- Misaligned: `addr[1:0]` ≠ 0.
- Out-of-range: any bit of `addr[31:AW+2]` ≠ 0.
- Either condition sets `err` = 1 in RESP. Storage is not modified and `rdata` is unchanged.

**Commit rule**

- Stores and loads both take effect on the edge that enters RESP.
- A store writes only the enabled bytes of word `addr[AW+1:2]`. A store with `be` = 0 is legal: it acks with no change.
- A load registers the word into `rdata` on the same edge.
- A load accepted after a store's `ack` returns the stored data.

**Storage**

- Contents are not reset and are undefined until written.
- Reset clears only control state and outputs.

## Timing

- Reset values: `ack` = 0, `err` = 0, `busy` = 0, `rdata` = 0, state IDLE, `cnt` = 0.
- Acceptance at edge T (IDLE with `req` = 1) gives `ack` high during cycle T+LATENCY, i.e. after LATENCY edges.
- `busy` is high from cycle T+1 through the `ack` cycle.
- Maximum throughput is one request per LATENCY+1 cycles. The earliest next acceptance is the edge at the end of the `ack` cycle +1, i.e. the first IDLE cycle.
- `req` held high continuously gives back-to-back transactions separated by one IDLE cycle. The inputs present in that IDLE cycle are the ones captured.
- Input changes during WAIT/RESP have no effect.
- Reset mid-operation (`rst` = 0 at any edge) returns to IDLE with all outputs at reset values.
  - A store not yet in RESP is discarded.
  - A store already committed stays committed.
- `rst` has priority over every other event on the same edge.

## Test plan

1. **Reset**: `rst` = 0 for 2 cycles with `req` = 1 → `ack`/`err`/`busy`/`rdata` all 0; no transaction accepted.
2. **Store then load, LATENCY = 2**
   - Store `addr` = 0x10, `wdata` = 0xDEADBEEF, `be` = 4'hF → `ack` 2 cycles after acceptance, `err` = 0.
   - Then a load of 0x10 → `rdata` = 0xDEADBEEF with `ack`.
3. **Byte enables**: over 0x10 = 0xDEADBEEF, store `wdata` = 0x11223344, `be` = 4'b0101 → a following load returns 0xDE22BE44.
4. **Errors**
   - Load 0x13 → `ack` + `err` = 1, `rdata` unchanged.
   - Store to 0x1000 with AW = 10 → `ack` + `err` = 1; a load of 0x0 shows no change.
5. **Busy/throughput, LATENCY = 1**
   - `req` held high for 6 cycles → 3 acks, one every 2 cycles.
   - `req` pulses during `busy` are ignored; `ack` count equals accepted-request count.
6. **Reset mid-store, LATENCY = 4**
   - Store 0x20 = 0xCAFEF00D, reset asserted 2 cycles after acceptance → no `ack`.
   - A subsequent load of 0x20 returns the pre-store value.
